pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Drives the hold (enable) and clear inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, taken branches/jumps resolved in EX, and multicycle EX operations (mul/div) that occupy EX for several cycles.
- Sits beside the datapath in the top-level pipeline. It is the only source of stall/clear controls.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/mc_latency_counter.sv | 40 ++++
 rtl/pipeline_hazard_controller.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   hz_state_t    : controller FSM states
//   REG_X0        : architectural zero register index (never a real producer)
//   hz_load_use() : load-use hazard detection between ID and EX
package hazard_pkg;

    typedef enum logic {HZ_RUN, HZ_MC_WAIT} hz_state_t;

    localparam int unsigned REG_X0 = 0;

    // Register addresses are passed zero-extended to 32 bits so one function
    // serves any REG_ADDR_W up to 32.
    function automatic logic hz_load_use(
        input logic        ex_mem_read,
        input logic [31:0] ex_rd,
        input logic [31:0] id_rs1,
        input logic [31:0] id_rs2,
        input logic        id_uses_rs1,
        input logic        id_uses_rs2
    );
        return ex_mem_read && (ex_rd != REG_X0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// Loadable down-counter tracking the remaining cycles of a multicycle EX op.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (stops at zero)
//   zero       : count is zero
module mc_latency_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Produces the hold and
// clear controls for the PC, IF/ID, ID/EX and EX/MEM registers, resolving
// load-use hazards, taken branches from EX and multicycle EX operations.
// Outputs are Mealy (same-cycle) and forced to 0 while reset is asserted.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs1/2   : source operands of the ID instruction
//   ex_rd, ex_mem_read            : destination / load flag of the EX instruction
//   ex_mc_start                   : multicycle op sitting in EX (level)
//   ex_branch_taken               : taken branch/jump resolved in EX
//   pc_hold, if_id_hold, id_ex_hold : register holds (1 = hold)
//   if_id_clear, id_ex_clear, ex_mem_clear : bubble insertion
//   mc_busy, mc_done              : multicycle status
// Optional feature macro HAZARD_PERF_EN adds saturating counters
//   perf_stall_cycles, perf_flushes, perf_mc_ops (PERF_W bits each).
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mc_start,
    input  logic                  ex_branch_taken,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  id_ex_hold,
    output logic                  if_id_clear,
    output logic                  id_ex_clear,
    output logic                  ex_mem_clear,
    output logic                  mc_busy,
    output logic                  mc_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_stall_cycles,
    output logic [PERF_W-1:0]     perf_flushes,
    output logic [PERF_W-1:0]     perf_mc_ops
`endif
);

    // Counter holds the cycles remaining after the first, so MC_LATENCY-2 at most.
    localparam int CNT_W   = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam int MC_LOAD = (MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0;

    if (MC_LATENCY < 1 || MC_LATENCY > 16 || PERF_W < 1 || REG_ADDR_W > 32) begin : g_bad_cfg
        $error("pipeline_hazard_controller: illegal parameter configuration");
    end

    hz_state_t state_d, state_q;
    logic      lu;
    logic      mc_load, mc_dec, mc_zero;
    logic      pc_hold_c, if_id_hold_c, id_ex_hold_c;
    logic      if_id_clear_c, id_ex_clear_c, ex_mem_clear_c;
    logic      mc_busy_c, mc_done_c, flush_c;

    assign lu = hz_load_use(ex_mem_read, 32'(ex_rd), 32'(id_rs1), 32'(id_rs2),
                            id_uses_rs1, id_uses_rs2);

    mc_latency_counter #(
        .CNT_W (CNT_W)
    ) u_mc_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (mc_load),
        .load_val (CNT_W'(MC_LOAD)),
        .dec      (mc_dec),
        .zero     (mc_zero)
    );

    always_comb begin
        state_d        = state_q;
        mc_load        = 1'b0;
        mc_dec         = 1'b0;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        id_ex_hold_c   = 1'b0;
        if_id_clear_c  = 1'b0;
        id_ex_clear_c  = 1'b0;
        ex_mem_clear_c = 1'b0;
        mc_busy_c      = 1'b0;
        mc_done_c      = 1'b0;
        flush_c        = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (ex_branch_taken) begin
                    if_id_clear_c = 1'b1;
                    id_ex_clear_c = 1'b1;
                    flush_c       = 1'b1;
                end else if (ex_mc_start) begin
                    if (MC_LATENCY > 1) begin
                        pc_hold_c      = 1'b1;
                        if_id_hold_c   = 1'b1;
                        id_ex_hold_c   = 1'b1;
                        ex_mem_clear_c = 1'b1;
                        mc_busy_c      = 1'b1;
                        mc_load        = 1'b1;
                        state_d        = HZ_MC_WAIT;
                    end else begin
                        // Single-cycle "multicycle" op behaves like any other instruction.
                        mc_done_c = 1'b1;
                    end
                end else if (lu) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_clear_c = 1'b1;
                end
            end
            HZ_MC_WAIT: begin
                pc_hold_c    = 1'b1;
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                mc_busy_c    = 1'b1;
                if (!mc_zero) begin
                    ex_mem_clear_c = 1'b1;
                    mc_dec         = 1'b1;
                end else begin
                    // Final cycle: EX/MEM is allowed to capture the result.
                    mc_done_c = 1'b1;
                    state_d   = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_hold      = pc_hold_c      & ~reset;
    assign if_id_hold   = if_id_hold_c   & ~reset;
    assign id_ex_hold   = id_ex_hold_c   & ~reset;
    assign if_id_clear  = if_id_clear_c  & ~reset;
    assign id_ex_clear  = id_ex_clear_c  & ~reset;
    assign ex_mem_clear = ex_mem_clear_c & ~reset;
    assign mc_busy      = mc_busy_c      & ~reset;
    assign mc_done      = mc_done_c      & ~reset;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_d, stall_q, flush_d, flush_q, mcops_d, mcops_q;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        mcops_d = mcops_q;
        if (pc_hold_c && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (flush_c   && (flush_q != '1)) flush_d = flush_q + 1'b1;
        if (mc_done_c && (mcops_q != '1)) mcops_d = mcops_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            mcops_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            mcops_q <= mcops_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushes      = flush_q;
    assign perf_mc_ops       = mcops_q;
`else
    logic unused_flush;
    assign unused_flush = flush_c;
`endif

    // A branch and a multicycle op can never both be resolving in EX.
    a_no_branch_with_mc : assert property (@(posedge clk) disable iff (reset)
        !(state_q == HZ_RUN && ex_branch_taken && ex_mc_start));

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mc_start, ex_branch_taken;

    // Output vector order: pc_hold, if_id_hold, id_ex_hold, if_id_clear,
    //                      id_ex_clear, ex_mem_clear, mc_busy, mc_done
    logic [7:0] out4, out1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [7:0] exp4;
        bit         chk1;
        logic [7:0] exp1;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    logic [31:0] ps4, pf4, pm4, ps1, pf1, pm1;
`endif

    pipeline_hazard_controller #(
        .REG_ADDR_W (5),
        .MC_LATENCY (4),
        .PERF_W     (32)
    ) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_mc_start     (ex_mc_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (out4[7]),
        .if_id_hold      (out4[6]),
        .id_ex_hold      (out4[5]),
        .if_id_clear     (out4[4]),
        .id_ex_clear     (out4[3]),
        .ex_mem_clear    (out4[2]),
        .mc_busy         (out4[1]),
        .mc_done         (out4[0])
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (ps4),
        .perf_flushes      (pf4),
        .perf_mc_ops       (pm4)
`endif
    );

    pipeline_hazard_controller #(
        .REG_ADDR_W (5),
        .MC_LATENCY (1),
        .PERF_W     (32)
    ) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_mc_start     (ex_mc_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (out1[7]),
        .if_id_hold      (out1[6]),
        .id_ex_hold      (out1[5]),
        .if_id_clear     (out1[4]),
        .id_ex_clear     (out1[3]),
        .ex_mem_clear    (out1[2]),
        .mc_busy         (out1[1]),
        .mc_done         (out1[0])
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (ps1),
        .perf_flushes      (pf1),
        .perf_mc_ops       (pm1)
`endif
    );

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (out4 !== e.exp4) begin
                n_fail++;
                $display("FAIL %s (lat4): got %b expected %b", e.name, out4, e.exp4);
            end
            if (e.chk1) begin
                n_checks++;
                if (out1 !== e.exp1) begin
                    n_fail++;
                    $display("FAIL %s (lat1): got %b expected %b", e.name, out1, e.exp1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_mc_start = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] e4,
                              input bit c1, input logic [7:0] e1);
        exp_t e;
        e.name = nm; e.exp4 = e4; e.chk1 = c1; e.exp1 = e1;
        sb.push_back(e);
    endtask

    task automatic set_lu_rs2(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clr();
        // Reset with a live load-use condition: outputs still forced low.
        tick(); set_lu_rs2(5'd5);                 expect_out("reset_state", 8'h00, 1, 8'h00);
        tick(); reset = 1'b0; clr();              expect_out("idle", 8'h00, 1, 8'h00);

        // Load-use on rs2: one-cycle stall, then released.
        tick(); clr(); set_lu_rs2(5'd5);          expect_out("lu_rs2", 8'hC8, 1, 8'hC8);
        tick(); clr();                            expect_out("lu_release", 8'h00, 1, 8'h00);
        tick(); clr(); set_lu_rs2(5'd0);          expect_out("lu_x0", 8'h00, 1, 8'h00);
        tick(); clr(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
                                                  expect_out("rs1_unused", 8'h00, 1, 8'h00);
        tick(); id_uses_rs1 = 1'b1;               expect_out("lu_rs1", 8'hC8, 1, 8'hC8);
        tick(); clr(); ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
                                                  expect_out("no_load", 8'h00, 1, 8'h00);

        // Branch beats a simultaneous load-use.
        tick(); clr(); set_lu_rs2(5'd3); ex_branch_taken = 1'b1;
                                                  expect_out("branch_over_lu", 8'h18, 1, 8'h18);

        // 4-cycle multicycle op; lat1 instance completes it immediately.
        tick(); clr(); ex_mc_start = 1'b1;        expect_out("mc_c1", 8'hE6, 1, 8'h01);
        tick(); set_lu_rs2(5'd9);                 expect_out("mc_c2_lu_ignored", 8'hE6, 0, 8'h00);
        tick(); clr(); ex_branch_taken = 1'b1;    expect_out("mc_c3_br_ignored", 8'hE6, 1, 8'h18);
        tick(); clr(); ex_mc_start = 1'b1;        expect_out("mc_c4_done", 8'hE3, 1, 8'h01);
        tick(); clr();                            expect_out("mc_back_to_run", 8'h00, 1, 8'h00);
        tick(); set_lu_rs2(5'd4);                 expect_out("lu_after_mc", 8'hC8, 1, 8'hC8);

        // Reset while waiting with two cycles left aborts without mc_done.
        tick(); clr(); ex_mc_start = 1'b1;        expect_out("abort_c1", 8'hE6, 0, 8'h00);
        tick(); reset = 1'b1;                     expect_out("abort_reset", 8'h00, 1, 8'h00);
        tick(); reset = 1'b0; clr();              expect_out("abort_after1", 8'h00, 1, 8'h00);
        tick();                                   expect_out("abort_after2", 8'h00, 1, 8'h00);
        tick();                                   expect_out("abort_after3", 8'h00, 1, 8'h00);

        // Counter workload: 2 flushes, one 4-cycle op, one load-use.
        tick(); clr(); ex_branch_taken = 1'b1;    expect_out("perf_br1", 8'h18, 1, 8'h18);
        tick();                                   expect_out("perf_br2", 8'h18, 1, 8'h18);
        tick(); clr(); ex_mc_start = 1'b1;        expect_out("perf_mc1", 8'hE6, 0, 8'h00);
        tick();                                   expect_out("perf_mc2", 8'hE6, 0, 8'h00);
        tick();                                   expect_out("perf_mc3", 8'hE6, 0, 8'h00);
        tick();                                   expect_out("perf_mc4", 8'hE3, 0, 8'h00);
        tick(); clr();                            expect_out("perf_idle", 8'h00, 1, 8'h00);
        tick(); set_lu_rs2(5'd12);                expect_out("perf_lu", 8'hC8, 1, 8'hC8);
        tick(); clr();                            expect_out("perf_end", 8'h00, 1, 8'h00);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

`ifdef HAZARD_PERF_EN
        n_checks++;
        if (ps4 !== 32'd5) begin
            n_fail++; $display("FAIL perf_stall_cycles: got %0d expected 5", ps4);
        end
        n_checks++;
        if (pf4 !== 32'd2) begin
            n_fail++; $display("FAIL perf_flushes: got %0d expected 2", pf4);
        end
        n_checks++;
        if (pm4 !== 32'd1) begin
            n_fail++; $display("FAIL perf_mc_ops: got %0d expected 1", pm4);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
